switch_debouncer: RTL and testbench
===================================

Name: switch_debouncer

Overview:
- Cleans the raw front-panel slide switches (sw1..sw4) before they reach the vending-machine coin/selection logic and the LED echo.
- Per channel: 2-flop synchronizer, then a stability counter, then a debounced level.
- Emits a one-cycle rising-edge pulse per channel for the downstream credit/selection FSM.
- Sits directly between the board switch pins and every consumer of switch state.

Parameters:
N_SW, 4, number of switch channels (bit i maps to sw(i+1)).
DEBOUNCE_CYCLES, 500000, consecutive clk_50 cycles a synchronized value must differ from the debounced level before it is accepted (10 ms at 50 MHz); legal range 2..2^24-1.

Ports:
clk_50  input  1  50 MHz system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
sw_raw  input  N_SW  raw asynchronous switch pins.
sw_level  output  N_SW  debounced, registered switch level.
sw_rise  output  N_SW  one-cycle pulse when sw_level bit goes 0->1.
sw_change  output  1  registered OR of all per-channel level changes in that cycle.

Behaviour:
- Clock and reset: one clock, clk_50. Reset rst_n is asynchronous and active-low.
- Reset values: sync flops = 0, counters = 0, sw_level = 0, sw_rise = 0, sw_change = 0. Assertion clears everything immediately, independent of clk_50. Deassertion is applied on the next clk_50 edge (the external reset is already synchronously released at board level).
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1. No other logic touches sync1.
- Counter width: CW = $clog2(DEBOUNCE_CYCLES+1). Each channel is independent.
- When sync2[i] == sw_level[i]: cnt[i] <= 0. Any bounce back to the stable value restarts the count.
- When sync2[i] != sw_level[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
- When sync2[i] != sw_level[i] and cnt[i] == DEBOUNCE_CYCLES-1:
  - sw_level[i] <= sync2[i]
  - cnt[i] <= 0
  - sw_rise[i] <= sync2[i] (1 only for a 0->1 transition)
- In every other cycle, sw_rise[i] <= 0. It never stays high more than 1 cycle.
- sw_change <= 1 in the same cycle any channel's level updates; otherwise 0.
- Latency: sw_raw changes before edge k and stays stable. Then sync2 holds the new value after edge k+1, and sw_level/sw_rise update at edge k+DEBOUNCE_CYCLES+1. The pulse is visible during the following cycle.
- Counter never wraps; it saturates by construction at DEBOUNCE_CYCLES-1 before reload.
- Simultaneous events: channels update independently in the same cycle; multiple sw_rise bits may be high together.
- Reset mid-count: counter and level clear. After release, a switch already high is accepted as a fresh 0->1 after the full latency and produces one sw_rise.
- Glitch shorter than DEBOUNCE_CYCLES: no change to sw_level and no pulse.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_FALL_PULSE_EN.
- When defined: adds output port sw_fall (N_SW bits). It pulses one cycle on each 1->0 sw_level transition, using the same timing as sw_rise; reset value 0.
- When undefined: the sw_fall port and its logic do not exist. The rest of the behaviour is identical.

Test Plan:
- DEBOUNCE_CYCLES=8, rst_n released; sw_raw=0001 applied before edge 10 and held -> sw_level=0001 and sw_rise=0001 at edge 19 only; sw_rise=0 at edge 20; sw_change=1 at edge 19 only.
- sw_raw[0] high for 5 cycles then low -> sw_level stays 0000; no sw_rise; no sw_change.
- Bounce: sw_raw[1] toggles every 3 cycles for 24 cycles, then held high from edge E -> exactly one sw_rise[1], at edge E+9; sw_level[1]=1 afterwards.
- sw_raw 0000->1111 in one step -> all four sw_rise bits high in the same single cycle; sw_level=1111.
- sw_raw[2]=1 held; rst_n pulsed low for 2 cycles at count 5 -> outputs 0 asynchronously during reset; after release, sw_rise[2] fires once after 9 more edges.
- With SWITCH_DEBOUNCER_FALL_PULSE_EN: sw_level[3] 1 -> sw_raw[3]=0 held -> sw_fall[3] pulses once 9 edges later; sw_rise stays 0.

Source files
------------

// File: rtl/switch_debouncer_if.sv
// Switch-side bundle: raw pins in, debounced level and event pulses out.
// sw_fall exists only when SWITCH_DEBOUNCER_FALL_PULSE_EN is defined.
interface switch_debouncer_if #(
  parameter int N_SW = 4
);

  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_level;
  logic [N_SW-1:0] sw_rise;
  logic            sw_change;
`ifdef SWITCH_DEBOUNCER_FALL_PULSE_EN
  logic [N_SW-1:0] sw_fall;
`endif

`ifdef SWITCH_DEBOUNCER_FALL_PULSE_EN
  modport master (
    output sw_raw,
    input  sw_level,
    input  sw_rise,
    input  sw_change,
    input  sw_fall
  );

  modport slave (
    input  sw_raw,
    output sw_level,
    output sw_rise,
    output sw_change,
    output sw_fall
  );
`else
  modport master (
    output sw_raw,
    input  sw_level,
    input  sw_rise,
    input  sw_change
  );

  modport slave (
    input  sw_raw,
    output sw_level,
    output sw_rise,
    output sw_change
  );
`endif

endinterface

// File: rtl/switch_debouncer.sv
// Per-channel 2-flop synchronizer, stability counter and debounced level with edge pulses.
// Optional falling-edge pulses are enabled by defining SWITCH_DEBOUNCER_FALL_PULSE_EN.
module switch_debouncer #(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk_50,
  input  logic            rst_n,
  switch_debouncer_if.slave sw
);

  localparam int             CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0] sync1;
  logic [N_SW-1:0] sync2;
  logic [N_SW-1:0] level_q;
  logic [N_SW-1:0] rise_q;
  logic            change_q;
  logic [CW-1:0]   cnt_q [N_SW];
  logic [N_SW-1:0] differ;
  logic [N_SW-1:0] accept;
`ifdef SWITCH_DEBOUNCER_FALL_PULSE_EN
  logic [N_SW-1:0] fall_q;
`endif

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw.sw_raw;
      sync2 <= sync1;
    end
  end

  // A channel is accepted once it has disagreed with the level for DEBOUNCE_CYCLES cycles.
  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < N_SW; i++) begin
      differ[i] = sync2[i] != level_q[i];
      accept[i] = differ[i] && (cnt_q[i] == TC);
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Accepted channels always disagree with the level, so an update is a bit flip.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      rise_q   <= '0;
      change_q <= 1'b0;
    end else begin
      level_q  <= level_q ^ accept;
      rise_q   <= accept & sync2;
      change_q <= |accept;
    end
  end

`ifdef SWITCH_DEBOUNCER_FALL_PULSE_EN
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      fall_q <= '0;
    end else begin
      fall_q <= accept & ~sync2;
    end
  end

  assign sw.sw_fall = fall_q;
`endif

  assign sw.sw_level  = level_q;
  assign sw.sw_rise   = rise_q;
  assign sw.sw_change = change_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=8 (level update 9 edges after the first sampling edge).
// Exercises sw_fall checks only when SWITCH_DEBOUNCER_FALL_PULSE_EN is defined.
module tb_switch_debouncer;

  localparam int N_SW = 4;
  localparam int DB   = 8;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  switch_debouncer_if #(.N_SW(N_SW)) bus ();

  switch_debouncer #(
    .N_SW            (N_SW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .sw     (bus.slave)
  );

  always #10 clk_50 = ~clk_50;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.sw_raw = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sw_raw = 4'b1111;
    tick();
    tick();
    tick();
    total++;
    if (bus.sw_level !== 4'b0000) begin
      bad++;
      $display("FAIL reset_level: got %b want %b", bus.sw_level, 4'b0000);
    end
    total++;
    if (bus.sw_rise !== 4'b0000) begin
      bad++;
      $display("FAIL reset_rise: got %b want %b", bus.sw_rise, 4'b0000);
    end
    total++;
    if (bus.sw_change !== 1'b0) begin
      bad++;
      $display("FAIL reset_change: got %b want %b", bus.sw_change, 1'b0);
    end
    bus.sw_raw = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_glitch();
    do_reset();
    bus.sw_raw = 4'b0001;
    for (int i = 1; i <= 5; i++) tick();
    bus.sw_raw = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (bus.sw_level !== 4'b0000 || bus.sw_rise !== 4'b0000 || bus.sw_change !== 1'b0) begin
        bad++;
        $display("FAIL glitch t%0d: got level=%b rise=%b change=%b want 0000/0000/0",
                 i, bus.sw_level, bus.sw_rise, bus.sw_change);
      end
    end
  endtask

  task automatic test_single_rise();
    logic [3:0] exp_level;
    logic [3:0] exp_rise;
    logic       exp_change;
    do_reset();
    bus.sw_raw = 4'b0001;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_level  = (i >= 10) ? 4'b0001 : 4'b0000;
      exp_rise   = (i == 10) ? 4'b0001 : 4'b0000;
      exp_change = (i == 10);
      total++;
      if (bus.sw_level !== exp_level || bus.sw_rise !== exp_rise || bus.sw_change !== exp_change) begin
        bad++;
        $display("FAIL single_rise t%0d: got level=%b rise=%b change=%b want %b/%b/%b",
                 i, bus.sw_level, bus.sw_rise, bus.sw_change, exp_level, exp_rise, exp_change);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_level;
    logic [3:0] exp_rise;
    for (int i = 0; i < 24; i++) begin
      bus.sw_raw = ((i / 3) % 2 == 0) ? 4'b0011 : 4'b0001;
      tick();
      total++;
      if (bus.sw_level !== 4'b0001 || bus.sw_rise !== 4'b0000) begin
        bad++;
        $display("FAIL bounce_hold t%0d: got level=%b rise=%b want 0001/0000",
                 i, bus.sw_level, bus.sw_rise);
      end
    end
    bus.sw_raw = 4'b0011;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_level = (i >= 10) ? 4'b0011 : 4'b0001;
      exp_rise  = (i == 10) ? 4'b0010 : 4'b0000;
      total++;
      if (bus.sw_level !== exp_level || bus.sw_rise !== exp_rise) begin
        bad++;
        $display("FAIL bounce_settle t%0d: got level=%b rise=%b want %b/%b",
                 i, bus.sw_level, bus.sw_rise, exp_level, exp_rise);
      end
    end
  endtask

  task automatic test_all_rise();
    logic [3:0] exp_level;
    logic [3:0] exp_rise;
    do_reset();
    bus.sw_raw = 4'b1111;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_level = (i >= 10) ? 4'b1111 : 4'b0000;
      exp_rise  = (i == 10) ? 4'b1111 : 4'b0000;
      total++;
      if (bus.sw_level !== exp_level || bus.sw_rise !== exp_rise || bus.sw_change !== (i == 10)) begin
        bad++;
        $display("FAIL all_rise t%0d: got level=%b rise=%b change=%b want %b/%b/%b",
                 i, bus.sw_level, bus.sw_rise, bus.sw_change, exp_level, exp_rise, (i == 10));
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] exp_level;
    logic [3:0] exp_rise;
    do_reset();
    bus.sw_raw = 4'b0001;
    for (int i = 1; i <= 10; i++) tick();
    total++;
    if (bus.sw_rise !== 4'b0001) begin
      bad++;
      $display("FAIL mid_pre_rise: got %b want %b", bus.sw_rise, 4'b0001);
    end
    bus.sw_raw = 4'b0101;
    for (int i = 1; i <= 7; i++) tick();
    rst_n = 1'b0;
    #2;
    total++;
    if (bus.sw_level !== 4'b0000 || bus.sw_rise !== 4'b0000 || bus.sw_change !== 1'b0) begin
      bad++;
      $display("FAIL mid_async_clear: got level=%b rise=%b change=%b want 0000/0000/0",
               bus.sw_level, bus.sw_rise, bus.sw_change);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_level = (i >= 10) ? 4'b0101 : 4'b0000;
      exp_rise  = (i == 10) ? 4'b0101 : 4'b0000;
      total++;
      if (bus.sw_level !== exp_level || bus.sw_rise !== exp_rise) begin
        bad++;
        $display("FAIL mid_after_release t%0d: got level=%b rise=%b want %b/%b",
                 i, bus.sw_level, bus.sw_rise, exp_level, exp_rise);
      end
    end
  endtask

  task automatic test_fall();
    logic [3:0] exp_level;
`ifdef SWITCH_DEBOUNCER_FALL_PULSE_EN
    logic [3:0] exp_fall;
`endif
    bus.sw_raw = 4'b1101;
    for (int i = 1; i <= 11; i++) tick();
    total++;
    if (bus.sw_level !== 4'b1101) begin
      bad++;
      $display("FAIL fall_setup: got %b want %b", bus.sw_level, 4'b1101);
    end
    bus.sw_raw = 4'b0101;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_level = (i >= 10) ? 4'b0101 : 4'b1101;
      total++;
      if (bus.sw_level !== exp_level || bus.sw_rise !== 4'b0000 || bus.sw_change !== (i == 10)) begin
        bad++;
        $display("FAIL fall t%0d: got level=%b rise=%b change=%b want %b/0000/%b",
                 i, bus.sw_level, bus.sw_rise, bus.sw_change, exp_level, (i == 10));
      end
`ifdef SWITCH_DEBOUNCER_FALL_PULSE_EN
      exp_fall = (i == 10) ? 4'b1000 : 4'b0000;
      total++;
      if (bus.sw_fall !== exp_fall) begin
        bad++;
        $display("FAIL fall_pulse t%0d: got %b want %b", i, bus.sw_fall, exp_fall);
      end
`endif
    end
  endtask

  initial begin
    bus.sw_raw = '0;
    test_reset();
    test_glitch();
    test_single_rise();
    test_bounce();
    test_all_rise();
    test_reset_mid_count();
    test_fall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
